// File: rtl/serial_ring_pkg.sv
// Shared constants and helpers for the serial word ring.
package serial_ring_pkg;

  localparam logic [1:0] MODE_RECIRC = 2'b00;
  localparam logic [1:0] MODE_WRITE  = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;
  localparam logic [1:0] MODE_CLEAR  = 2'b11;

  // Counter width for n states, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_word_ring_shift_ring.sv
// Bulk ring storage: shifts left by one when enabled, new bit enters at the LSB.
module shift_ring #(
  parameter int DEPTH_BITS = 512,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  new_bit,
  output logic                  ring_msb,
  output logic [WORD_WIDTH-2:0] low_bits
);

  // Storage is intentionally not reset; contents survive a reset.
  logic [DEPTH_BITS-1:0] ring;

  always_ff @(posedge clk) begin
    if (en) begin
      ring <= {ring[DEPTH_BITS-2:0], new_bit};
    end
  end

  assign ring_msb = ring[DEPTH_BITS-1];
  assign low_bits = ring[WORD_WIDTH-2:0];

endmodule

// File: rtl/serial_word_ring.sv
// Serial circular word buffer: shifts one bit per clock and emits each completed word in parallel.
module serial_word_ring
  import serial_ring_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int WORD_COUNT = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [1:0]                          mode,
  input  logic                                din,
  output logic [WORD_WIDTH-1:0]               dout_word,
  output logic                                word_valid,
  output logic [idx_width(WORD_COUNT)-1:0]    word_index,
  output logic                                frame_start,
  output logic                                bit_out
);

  localparam int BCW = idx_width(WORD_WIDTH);
  localparam int WCW = idx_width(WORD_COUNT);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_WIDTH - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(WORD_COUNT - 1);

  logic [BCW-1:0]        bit_cnt;
  logic [WCW-1:0]        word_cnt;
  logic                  shifting;
  logic                  shift_en;
  logic                  new_bit;
  logic                  ring_msb;
  logic [WORD_WIDTH-2:0] low_bits;

  assign shifting = (mode != MODE_HOLD);
  // The ring has no reset, so keep it from moving while reset is asserted.
  assign shift_en = shifting & ~reset;

  always_comb begin
    new_bit = 1'b0;
    case (mode)
      MODE_WRITE:  new_bit = din;
      MODE_RECIRC: new_bit = ring_msb;
      default:     new_bit = 1'b0;
    endcase
  end

  shift_ring #(
    .DEPTH_BITS (WORD_COUNT * WORD_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_ring (
    .clk      (clk),
    .en       (shift_en),
    .new_bit  (new_bit),
    .ring_msb (ring_msb),
    .low_bits (low_bits)
  );

  assign bit_out = ring_msb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      word_cnt    <= '0;
      dout_word   <= '0;
      word_index  <= '0;
      word_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else if (shifting) begin
      bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      if (bit_cnt == BIT_LAST) begin
        dout_word   <= {low_bits, new_bit};
        word_index  <= word_cnt;
        frame_start <= (word_cnt == '0);
        word_valid  <= 1'b1;
        word_cnt    <= (word_cnt == WORD_LAST) ? '0 : word_cnt + 1'b1;
      end else begin
        word_valid  <= 1'b0;
        frame_start <= 1'b0;
      end
    end else begin
      word_valid  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_word_ring.sv
// Randomized and directed bench for serial_word_ring against a queue-based ring model.
module tb_serial_word_ring;
  import serial_ring_pkg::*;

  localparam int WW = 8;
  localparam int WC = 4;
  localparam int NB = WW * WC;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       din;
  logic [WW-1:0] dout_word;
  logic       word_valid;
  logic [1:0] word_index;
  logic       frame_start;
  logic       bit_out;

  serial_word_ring #(.WORD_WIDTH(WW), .WORD_COUNT(WC)) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .din         (din),
    .dout_word   (dout_word),
    .word_valid  (word_valid),
    .word_index  (word_index),
    .frame_start (frame_start),
    .bit_out     (bit_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Reference model: ring as a FIFO of bits (front = oldest), plus shift count since reset.
  bit ring_q[$];
  bit known_q[$];
  bit [7:0] win;
  bit [7:0] win_k;
  int shifts;
  bit exp_valid, exp_fs, exp_dk;
  bit [7:0] exp_dout;
  int exp_idx;

  typedef struct { bit [7:0] w; int idx; bit fs; } strobe_t;
  strobe_t stb_q[$];

  task automatic model_edge(input logic [1:0] m, input bit d, input bit rst);
    bit nb, nk;
    if (rst) begin
      shifts = 0; exp_valid = 0; exp_fs = 0; exp_idx = 0; exp_dout = 0; exp_dk = 1;
    end else if (m != MODE_HOLD) begin
      nb = (m == MODE_WRITE) ? d : (m == MODE_CLEAR) ? 1'b0 : ring_q[0];
      nk = (m == MODE_RECIRC) ? known_q[0] : 1'b1;
      void'(ring_q.pop_front());  ring_q.push_back(nb);
      void'(known_q.pop_front()); known_q.push_back(nk);
      win = {win[6:0], nb};
      win_k = {win_k[6:0], nk};
      shifts++;
      if (shifts % WW == 0) begin
        exp_valid = 1;
        exp_dout = win;
        exp_dk = &win_k;
        exp_idx = ((shifts / WW) - 1) % WC;
        exp_fs = (exp_idx == 0);
      end else begin
        exp_valid = 0; exp_fs = 0;
      end
    end else begin
      exp_valid = 0; exp_fs = 0;
    end
  endtask

  task automatic step(input logic [1:0] m, input bit d, input bit rst);
    mode = m; din = d; reset = rst;
    @(posedge clk);
    model_edge(m, d, rst);
    #1;
    check_val("word_valid", word_valid, exp_valid);
    check_val("frame_start", frame_start, exp_fs);
    check_val("word_index", word_index, exp_idx);
    if (exp_dk) check_val("dout_word", dout_word, exp_dout);
    if (known_q[0]) check_val("bit_out", bit_out, ring_q[0]);
    if (word_valid) stb_q.push_back('{dout_word, int'(word_index), frame_start});
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) step(MODE_WRITE, b[i], 1'b0);
  endtask

  task automatic run_mode(input logic [1:0] m, input int n);
    for (int i = 0; i < n; i++) step(m, 1'b0, 1'b0);
  endtask

  logic [7:0] exp_words [4];
  int idx_hist [4];
  int zero_cnt;

  initial begin
    for (int i = 0; i < NB; i++) begin ring_q.push_back(1'b0); known_q.push_back(1'b0); end
    win = 0; win_k = 0; shifts = 0;
    exp_valid = 0; exp_fs = 0; exp_idx = 0; exp_dout = 0; exp_dk = 1;
    reset = 1'b1; mode = MODE_HOLD; din = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) step(MODE_HOLD, 1'b0, 1'b1);
    run_mode(MODE_HOLD, 10);
    check_val("idle_dout", dout_word, 32'h00);

    write_byte(8'hA5);
    check_val("a5_valid", word_valid, 32'h1);
    check_val("a5_dout", dout_word, 32'hA5);
    check_val("a5_fs", frame_start, 32'h1);
    check_val("a5_idx", word_index, 32'h0);
    step(MODE_HOLD, 1'b0, 1'b0);
    check_val("a5_valid_drop", word_valid, 32'h0);
    check_val("a5_dout_hold", dout_word, 32'hA5);

    step(MODE_HOLD, 1'b0, 1'b1);
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
    stb_q.delete();
    run_mode(MODE_RECIRC, 32);
    exp_words[0] = 8'h11; exp_words[1] = 8'h22; exp_words[2] = 8'h33; exp_words[3] = 8'h44;
    check_val("recirc_count", stb_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < stb_q.size(); i++) begin
      check_val("recirc_word", stb_q[i].w, exp_words[i]);
      check_val("recirc_idx", stb_q[i].idx, i);
      check_val("recirc_fs", stb_q[i].fs, (i == 0));
    end

    stb_q.delete();
    run_mode(MODE_RECIRC, 3);
    run_mode(MODE_HOLD, 5);
    check_val("hold_no_strobe", stb_q.size(), 32'd0);
    run_mode(MODE_RECIRC, 5);
    check_val("hold_resume_valid", word_valid, 32'h1);
    check_val("hold_resume_dout", dout_word, 32'h11);
    check_val("hold_resume_count", stb_q.size(), 32'd1);

    stb_q.delete();
    run_mode(MODE_CLEAR, 32);
    run_mode(MODE_RECIRC, 32);
    check_val("clear_count", stb_q.size(), 32'd8);
    for (int i = 0; i < 4; i++) idx_hist[i] = 0;
    zero_cnt = 0;
    foreach (stb_q[i]) begin
      if (stb_q[i].w == 8'h00) zero_cnt++;
      if (stb_q[i].idx >= 0 && stb_q[i].idx < 4) idx_hist[stb_q[i].idx]++;
    end
    check_val("clear_zero_words", zero_cnt, 32'd8);
    for (int i = 0; i < 4; i++) check_val("clear_idx_hist", idx_hist[i], 32'd2);

    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
    run_mode(MODE_RECIRC, 4);
    step(MODE_HOLD, 1'b0, 1'b1);
    check_val("rst_valid", word_valid, 32'h0);
    check_val("rst_dout", dout_word, 32'h0);
    run_mode(MODE_RECIRC, 8);
    check_val("realign_valid", word_valid, 32'h1);
    check_val("realign_dout", dout_word, 32'h12);
    check_val("realign_idx", word_index, 32'h0);
    check_val("realign_fs", frame_start, 32'h1);

    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      step(2'($urandom_range(0, 3)), 1'($urandom), r < 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
